// File: rtl/interrupt_controller.sv
// Round-robin interrupt controller: edge-captured sources, one CPU request, bus-mapped pending/enable/vector.
// Source edge to CPU_INT_RAISE is 3 cycles; after each acknowledge the request line is held off HoldoffCycles cycles.
module interrupt_controller #(
  parameter logic [7:0] CtrlBaseAddr  = 8'hE0,
  parameter int         NumSources    = 4,
  parameter logic [7:0] InitialEnable = 8'hFF,
  parameter int         HoldoffCycles = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  wire  [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  input  logic [NumSources-1:0] SRC_INT_RAISE,
  output logic [NumSources-1:0] SRC_INT_ACK,
  output logic                  CPU_INT_RAISE,
  output logic [2:0]            CPU_INT_VECTOR,
  input  logic                  CPU_INT_ACK
);

  localparam logic [7:0] SrcMask = 8'((1 << NumSources) - 1);

  typedef enum logic [1:0] {IDLE, ARB, REQ, HOLD} state_t;

  state_t     state, state_nxt;
  logic [7:0] src_ext, src_prev, rise, pending, enable, cand, clr;
  logic [7:0] hold_cnt, rd_dat, rd_nxt;
  logic [2:0] rr_ptr, grant, vector;
  logic       grant_vld, bus_match, wr_en, rd_en, ack_take;

  assign src_ext   = 8'(SRC_INT_RAISE);
  assign rise      = src_ext & ~src_prev;
  assign cand      = pending & enable & SrcMask;
  assign bus_match = (BUS_ADDR[7:2] == CtrlBaseAddr[7:2]);
  assign wr_en     = bus_match && BUS_WE;
  assign ack_take  = (state == REQ) && CPU_INT_ACK;

  always_comb begin
    clr = '0;
    if (wr_en && BUS_ADDR[1:0] == 2'd3) clr = BUS_DATA;
    if (ack_take) clr = clr | (8'd1 << vector);
  end

  // Descending scan so the last hit is the first candidate at or after rr_ptr.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NumSources - 1; k >= 0; k--) begin
      if (cand[3'((int'(rr_ptr) + k) % NumSources)]) begin
        grant     = 3'((int'(rr_ptr) + k) % NumSources);
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|cand) state_nxt = ARB;
      ARB:     state_nxt = grant_vld ? REQ : IDLE;
      REQ:     if (CPU_INT_ACK) state_nxt = HOLD;
      HOLD:    if (hold_cnt == 8'(HoldoffCycles - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CPU_INT_RAISE = (state == REQ);
  end

  assign CPU_INT_VECTOR = vector;

  // New edges are OR'd in after the clear so a same-cycle set wins.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      src_prev    <= '0;
      pending     <= '0;
      enable      <= InitialEnable;
      rr_ptr      <= '0;
      vector      <= '0;
      hold_cnt    <= '0;
      SRC_INT_ACK <= '0;
    end else begin
      src_prev    <= src_ext;
      pending     <= ((pending & ~clr) | rise) & SrcMask;
      SRC_INT_ACK <= '0;
      hold_cnt    <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
      if (wr_en && BUS_ADDR[1:0] == 2'd1) enable <= BUS_DATA;
      if (state == ARB && grant_vld) vector <= grant;
      if (ack_take) begin
        SRC_INT_ACK <= NumSources'(1) << vector;
        rr_ptr      <= 3'((int'(vector) + 1) % NumSources);
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (BUS_ADDR[1:0])
      2'd0:    rd_nxt = pending;
      2'd1:    rd_nxt = enable;
      2'd2:    rd_nxt = {4'b0, CPU_INT_RAISE, vector};
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_en  <= 1'b0;
      rd_dat <= '0;
    end else begin
      rd_en  <= bus_match && !BUS_WE;
      rd_dat <= rd_nxt;
    end
  end

  assign BUS_DATA = rd_en ? rd_dat : 8'hZZ;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized and directed bench for interrupt_controller against a timestamp-based reference model.
// The shared bus is pulled high so an undriven bus reads 8'hFF.
module tb_interrupt_controller;
  localparam int N = 4;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  tri1  [7:0]   bus_data;
  logic [7:0]   bus_addr = 8'h00;
  logic [7:0]   tb_dat = 8'h00;
  logic         bus_we = 1'b0;
  logic [N-1:0] src = '0;
  logic [N-1:0] src_ack;
  logic         cpu_raise;
  logic [2:0]   cpu_vec;
  logic         cpu_ack = 1'b0;

  int total = 0;
  int bad = 0;

  assign bus_data = bus_we ? tb_dat : 8'hzz;
  always #5 clk = ~clk;

  interrupt_controller #(
    .CtrlBaseAddr(8'hE0), .NumSources(N), .InitialEnable(8'hFF), .HoldoffCycles(H)
  ) dut (
    .CLK(clk), .RESET(reset), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .SRC_INT_RAISE(src), .SRC_INT_ACK(src_ack), .CPU_INT_RAISE(cpu_raise),
    .CPU_INT_VECTOR(cpu_vec), .CPU_INT_ACK(cpu_ack)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending bitmap plus timestamps for when arbitration may next occur.
  logic [7:0]   m_pend = 8'h00, m_en = 8'hFF, m_cand, m_clr, m_rd_val = 8'h00;
  logic [N-1:0] m_src_last = '0, m_ack = '0;
  int           m_rr = 0, m_vec = 0, m_cyc = 0, m_free_at = 0, m_arb_at = -1;
  bit           m_raise = 1'b0, m_rd_en = 1'b0;

  // Lowest pending index at or above rr, else lowest pending index overall.
  function automatic int pick(input logic [7:0] c, input int rr);
    int best = -1;
    for (int i = N - 1; i >= 0; i--) if (c[i] && i >= rr) best = i;
    if (best < 0) for (int i = N - 1; i >= 0; i--) if (c[i]) best = i;
    return best;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 8'h00; m_en = 8'hFF; m_rr = 0; m_vec = 0; m_raise = 1'b0; m_ack = '0;
      m_src_last = '0; m_cyc = 0; m_free_at = 0; m_arb_at = -1; m_rd_en = 1'b0; m_rd_val = 8'h00;
    end else begin
      m_cand  = m_pend & m_en & 8'h0F;
      m_clr   = 8'h00;
      m_rd_en = (bus_addr >= 8'hE0) && (bus_addr <= 8'hE3) && !bus_we;
      if (bus_addr == 8'hE0)      m_rd_val = m_pend;
      else if (bus_addr == 8'hE1) m_rd_val = m_en;
      else if (bus_addr == 8'hE2) m_rd_val = {4'd0, m_raise, 3'(m_vec)};
      else                        m_rd_val = 8'h00;
      if (bus_we && bus_addr == 8'hE3) m_clr = tb_dat;
      m_ack = '0;
      if (m_raise) begin
        if (cpu_ack) begin
          m_ack     = N'(1) << m_vec;
          m_clr     = m_clr | (8'd1 << m_vec);
          m_rr      = (m_vec + 1) % N;
          m_raise   = 1'b0;
          m_free_at = m_cyc + 1 + H;
        end
      end else if (m_arb_at == m_cyc) begin
        m_arb_at = -1;
        if (m_cand != 0) begin
          m_vec   = pick(m_cand, m_rr);
          m_raise = 1'b1;
        end
      end else if (m_cyc >= m_free_at && m_cand != 0) begin
        m_arb_at = m_cyc + 1;
      end
      m_pend = ((m_pend & ~m_clr) | (8'(src) & ~8'(m_src_last))) & 8'h0F;
      if (bus_we && bus_addr == 8'hE1) m_en = tb_dat;
      m_src_last = src;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check_val("raise", {7'd0, cpu_raise}, {7'd0, m_raise});
    check_val("vector", 8'(cpu_vec), 8'(m_vec));
    check_val("src_ack", 8'(src_ack), 8'(m_ack));
    if (!bus_we) check_val("bus", bus_data, m_rd_en ? m_rd_val : 8'hFF);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a; tb_dat = d; bus_we = 1'b1;
    step(1);
    bus_we = 1'b0; bus_addr = 8'h00;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    bus_addr = a; bus_we = 1'b0;
    step(1);
    bus_addr = 8'h00;
    @(negedge clk);
    d = bus_data;
    step(1);
  endtask

  task automatic pulse_ack();
    cpu_ack = 1'b1;
    step(1);
    cpu_ack = 1'b0;
  endtask

  task automatic wait_raise(input string tag);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (cpu_raise) break;
      n++;
    end
    if (n >= 40) check_val(tag, {7'd0, cpu_raise}, 8'd1);
    step(1);
  endtask

  task automatic do_reset();
    reset = 1'b0; src = '0; cpu_ack = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    logic [7:0] rd;
    int lat;
    #1 reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    check_val("rst_raise", {7'd0, cpu_raise}, 8'd0);
    bus_rd(8'hE1, rd);
    check_val("rst_enable", rd, 8'hFF);

    // Single source: edge to request latency and a one-cycle acknowledge.
    src = 4'b0010;
    lat = 0;
    @(negedge clk);
    while (!cpu_raise && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency", 8'(lat), 8'd3);
    check_val("vec_single", 8'(cpu_vec), 8'd1);
    step(1);
    pulse_ack();
    check_val("ack_single", 8'(src_ack), 8'h02);
    check_val("raise_drop", {7'd0, cpu_raise}, 8'd0);
    step(1);
    check_val("ack_one_cycle", 8'(src_ack), 8'h00);
    bus_rd(8'hE0, rd);
    check_val("pend_after_ack", rd, 8'h00);

    // Round-robin with a re-raise during holdoff and pointer wrap.
    do_reset();
    src = 4'b0101;
    wait_raise("rr_first_to");
    check_val("rr_first", 8'(cpu_vec), 8'd0);
    pulse_ack();
    src = 4'b0100;
    step(1);
    src = 4'b0101;
    wait_raise("rr_second_to");
    check_val("rr_second", 8'(cpu_vec), 8'd2);
    pulse_ack();
    wait_raise("rr_wrap_to");
    check_val("rr_wrap", 8'(cpu_vec), 8'd0);
    pulse_ack();

    // Masking.
    src = 4'b0000;
    step(8);
    bus_wr(8'hE1, 8'hFE);
    src = 4'b0001;
    step(8);
    check_val("mask_no_raise", {7'd0, cpu_raise}, 8'd0);
    bus_rd(8'hE0, rd);
    check_val("mask_pend", rd, 8'h01);
    bus_wr(8'hE1, 8'hFF);
    wait_raise("unmask_to");
    check_val("unmask_vec", 8'(cpu_vec), 8'd0);
    pulse_ack();

    // Clear colliding with a new edge; level held through ack does not re-request.
    src = 4'b0000;
    step(8);
    src = 4'b0100;
    bus_wr(8'hE3, 8'h04);
    bus_rd(8'hE0, rd);
    check_val("clr_collide", rd & 8'h04, 8'h04);
    wait_raise("collide_to");
    check_val("collide_vec", 8'(cpu_vec), 8'd2);
    bus_rd(8'hE2, rd);
    check_val("rd_vector_reg", rd, 8'h0A);
    pulse_ack();
    step(20);
    check_val("held_no_repeat", {7'd0, cpu_raise}, 8'd0);

    // Stray acknowledge in idle and tristate outside the window.
    pulse_ack();
    check_val("stray_ack", 8'(src_ack), 8'h00);
    step(5);
    check_val("stray_raise", {7'd0, cpu_raise}, 8'd0);
    bus_rd(8'h10, rd);
    check_val("bus_z_far", rd, 8'hFF);
    bus_rd(8'hE4, rd);
    check_val("bus_z_near", rd, 8'hFF);

    // Asynchronous reset during a request.
    src = 4'b0000;
    step(2);
    bus_wr(8'hE1, 8'h5A);
    src = 4'b0010;
    wait_raise("rst_req_to");
    reset = 1'b0;
    src = 4'b0000;
    #1;
    check_val("async_drop", {7'd0, cpu_raise}, 8'd0);
    step(2);
    reset = 1'b1;
    step(1);
    check_val("rst_no_ack", 8'(src_ack), 8'h00);
    bus_rd(8'hE1, rd);
    check_val("rst_enable2", rd, 8'hFF);

    // Random traffic; the per-cycle checker compares against the model.
    for (int i = 0; i < 1500; i++) begin
      int op;
      src = src ^ N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      cpu_ack = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 15);
      if (op == 0)      bus_wr(8'hE3, 8'($urandom_range(0, 255)));
      else if (op == 1) bus_wr(8'hE1, 8'($urandom_range(0, 255)));
      else if (op == 2) bus_wr(8'hE0 + 8'($urandom_range(0, 2) * 2), 8'($urandom_range(0, 255)));
      else if (op == 3) bus_rd(8'hE0 + 8'($urandom_range(0, 3)), rd);
      else              step(1);
    end
    cpu_ack = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects interrupt raise lines from up to 8 bus peripherals (timer, mouse, IR, etc.) and arbitrates them round-robin onto the processor's single interrupt request.
- Presents the winning source's index as a vector and returns the processor's acknowledge to the winning peripheral only.
- Sits on the shared 8-bit memory-mapped bus; exposes pending, enable and vector registers to software.

Parameters:
- CtrlBaseAddr, 8'hE0, base address of the 4-byte register window.
- NumSources, 4, number of interrupt sources; legal range 1..8.
- InitialEnable, 8'hFF, reset value of the enable register (bit i = 1 enables source i).
- HoldoffCycles, 4, idle cycles enforced after each acknowledge before the next request; legal range 1..255.

Ports:
- CLK  input  1  system clock (100 MHz).
- RESET  input  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus; tristated when not reading this block.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write strobe.
- SRC_INT_RAISE  input  NumSources  per-peripheral interrupt raise level.
- SRC_INT_ACK  output  NumSources  per-peripheral acknowledge, one-cycle pulse.
- CPU_INT_RAISE  output  1  interrupt request to processor.
- CPU_INT_VECTOR  output  3  index of the source being requested.
- CPU_INT_ACK  input  1  processor acknowledge, one-cycle pulse.

Behaviour:
- Reset (RESET low, asynchronous):
  - pending=0, enable=InitialEnable, rr_ptr=0, FSM=IDLE, holdoff counter=0.
  - CPU_INT_RAISE=0, CPU_INT_VECTOR=0, SRC_INT_ACK=0, bus read-enable=0 (BUS_DATA high-Z).
  - Reset mid-request drops CPU_INT_RAISE immediately; no SRC_INT_ACK is issued.
- Edge capture:
  - Previous SRC_INT_RAISE is registered each cycle.
  - A 0->1 transition on bit i sets pending[i] on the next edge.
  - A raise held high does not re-pend.
- Set/clear priority: if pending[i] is set and cleared (bus clear or acknowledge) in the same cycle, set wins and the bit stays 1.
- Candidates are pending & enable & ((1<<NumSources)-1).
- FSM:
  - IDLE: if any candidate, go to ARB.
  - ARB (1 cycle):
    - Grant the first candidate at or after rr_ptr, scanning upward with wrap to 0.
    - Latch the index into CPU_INT_VECTOR.
    - Go to REQ.
    - If the candidate set emptied this cycle, return to IDLE.
  - REQ:
    - CPU_INT_RAISE=1; vector held stable.
    - Disabling or bus-clearing the granted source while in REQ does not withdraw the request (already committed).
    - On CPU_INT_ACK: SRC_INT_ACK[g]=1 on the next cycle, exactly one cycle; pending[g] cleared; rr_ptr=(g+1) mod NumSources; CPU_INT_RAISE=0 on that same cycle; go to HOLD.
  - HOLD:
    - Count HoldoffCycles cycles, then go to IDLE.
    - Edges still capture into pending during HOLD.
- CPU_INT_ACK outside REQ is ignored.
- Latency: a source edge at cycle 0 gives pending at cycle 1, ARB at cycle 2, CPU_INT_RAISE high at cycle 3.
- Register map (writes take effect on the next edge; reads are registered like the other peripherals):
  - +0 R: pending, zero-extended to 8 bits.
  - +1 RW: enable.
  - +2 R: {4'b0, CPU_INT_RAISE, CPU_INT_VECTOR}.
  - +3 W: write-1-to-clear pending (pending &= ~BUS_DATA).
  - Writes to +0 and +2 are ignored.
- Read enable is registered from an address match with BUS_WE=0. BUS_DATA drives the register value while read enable is set, otherwise 8'hZZ.
- Bits at or above NumSources: read 0 in pending; stored but ignored in enable.

Test Plan:
- Single source: reset; raise SRC[1] at cycle 10 → CPU_INT_RAISE=1, VECTOR=1 at cycle 13. CPU_INT_ACK pulse → SRC_INT_ACK=4'b0010 for one cycle. Pending reads 0x00 at +0.
- Round-robin: SRC[0] and SRC[2] rise in the same cycle → grant 0 first. After ack and holdoff, grant 2. Raise 0 again during HOLD → granted only after 2, and rr_ptr=3 wraps to 0.
- Mask: write 0xFE to +1, then raise SRC[0] → no CPU_INT_RAISE and pending=0x01. Write 0xFF → request appears within 2 cycles, VECTOR=0.
- Clear collision: bus write 0x04 to +3 in the same cycle as a new SRC[2] rising edge → pending[2] remains 1. Level held high through ack → no second request.
- Bus tristate: read +2 during REQ → 0x0A for VECTOR=2. With any non-window address, BUS_DATA is Z. A stray CPU_INT_ACK in IDLE has no effect.
- Async reset: assert RESET low during REQ → CPU_INT_RAISE=0 without waiting for a clock edge, enable=0xFF after release, no SRC_INT_ACK pulse.
